// File: rtl/fitbit_step_tracker_pkg.sv
// Shared types and widths for the step tracker; no logic, no latency.
// Backpressure: none (constants only).
package fitbit_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } run_state_t;

    localparam int STEP_W          = 14;
    localparam int DIST_W          = 9;
    localparam int SEC_W           = 4;
    localparam int SECTIME_W       = 9;
    localparam int HALF_MILE_SHIFT = 10;

    localparam logic [SECTIME_W-1:0] SECTIME_MAX = 9'd511;
endpackage

// File: rtl/fitbit_step_tracker_if.sv
// Step tracker I/O bundle: raw PULSE in, display metrics and 1 Hz tick out.
// Optional sat flag under TRACKER_SAT_FLAG_EN; no handshake, outputs are free-running registers.
interface fitbit_step_tracker_if;
    import fitbit_pkg::*;

    logic                 PULSE;
    logic                 slowClk;
    logic [STEP_W-1:0]    stepcnt;
    logic [DIST_W-1:0]    distance;
    logic [SEC_W-1:0]     sec;
    logic [SECTIME_W-1:0] sectime;
`ifdef TRACKER_SAT_FLAG_EN
    logic                 sat;

    modport master (output PULSE, input slowClk, stepcnt, distance, sec, sectime, sat);
    modport slave  (input PULSE, output slowClk, stepcnt, distance, sec, sectime, sat);
`else
    modport master (output PULSE, input slowClk, stepcnt, distance, sec, sectime);
    modport slave  (input PULSE, output slowClk, stepcnt, distance, sec, sectime);
`endif
endinterface

// File: rtl/fitbit_step_tracker_step_pulse_sync.sv
// 2-FF synchronizer plus rising-edge detect; step edge 2 CLK after PULSE is sampled.
// Backpressure: none; one single-cycle edge per PULSE rise.
module step_pulse_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic i_pulse,
    output logic o_step_edge
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_pulse;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_step_edge = r_sync2 & ~r_prev;
endmodule

// File: rtl/fitbit_step_tracker.sv
// Step counter, distance, windowed-active and high-activity metrics plus 1 Hz tick; 3 CLK PULSE->stepcnt.
// Backpressure: none; optional sat output under TRACKER_SAT_FLAG_EN.
module fitbit_step_tracker
    import fitbit_pkg::*;
#(
    parameter int CLKS_PER_SEC = 100_000_000,
    parameter int STEP_MAX     = 9999,
    parameter int SEC_WINDOW   = 9,
    parameter int SEC_RATE     = 32,
    parameter int HI_RATE      = 64,
    parameter int RUN_MIN      = 60
) (
    input  logic                  CLK,
    input  logic                  RESET,
    fitbit_step_tracker_if.slave  bus
);
    localparam int DIV_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam int RUN_W = $clog2(RUN_MIN + 1);

    logic                 w_step_edge;
    logic                 w_tick;
    logic                 w_hi;
    logic [8:0]           w_rate_fin;
    logic [RUN_W-1:0]     w_run_len_p1;
    logic [SECTIME_W:0]   w_sectime_sum;
    logic [SECTIME_W-1:0] w_sectime_add;
    logic [SECTIME_W-1:0] w_sectime_inc;
    logic [STEP_W-1:0]    w_stepcnt_nxt;
    logic [SECTIME_W-1:0] w_sectime_nxt;
    logic [RUN_W-1:0]     w_run_len_nxt;
    run_state_t           w_state_nxt;

    logic [DIV_W-1:0]     r_div;
    logic [7:0]           r_rate_cnt;
    logic [3:0]           r_elapsed;
    logic [RUN_W-1:0]     r_run_len;
    run_state_t           r_state;
    logic                 r_slowclk;
    logic [STEP_W-1:0]    r_stepcnt;
    logic [DIST_W-1:0]    r_distance;
    logic [SEC_W-1:0]     r_sec;
    logic [SECTIME_W-1:0] r_sectime;

    step_pulse_sync u_sync (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_pulse     (bus.PULSE),
        .o_step_edge (w_step_edge)
    );

    // A step landing on the tick cycle belongs to the second that is ending.
    assign w_tick        = (r_div == DIV_W'(CLKS_PER_SEC - 1));
    assign w_rate_fin    = {1'b0, r_rate_cnt} + {8'd0, w_step_edge};
    assign w_hi          = (w_rate_fin >= 9'(HI_RATE));
    assign w_run_len_p1  = r_run_len + RUN_W'(1);
    assign w_sectime_sum = {1'b0, r_sectime} + (SECTIME_W+1)'(RUN_MIN);
    assign w_sectime_add = w_sectime_sum[SECTIME_W] ? SECTIME_MAX : w_sectime_sum[SECTIME_W-1:0];
    assign w_sectime_inc = (r_sectime == SECTIME_MAX) ? r_sectime : r_sectime + SECTIME_W'(1);
    assign w_stepcnt_nxt = (w_step_edge && (r_stepcnt != STEP_W'(STEP_MAX)))
                         ? r_stepcnt + STEP_W'(1) : r_stepcnt;

    always_comb begin
        w_state_nxt   = r_state;
        w_run_len_nxt = r_run_len;
        w_sectime_nxt = r_sectime;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (w_hi) begin
                        w_run_len_nxt = RUN_W'(1);
                        w_state_nxt   = RUN;
                    end
                end
                RUN: begin
                    if (!w_hi) begin
                        w_run_len_nxt = '0;
                        w_state_nxt   = IDLE;
                    end else if (w_run_len_p1 == RUN_W'(RUN_MIN)) begin
                        w_sectime_nxt = w_sectime_add;
                        w_state_nxt   = HOLD;
                    end else begin
                        w_run_len_nxt = w_run_len_p1;
                    end
                end
                HOLD: begin
                    if (w_hi) begin
                        w_sectime_nxt = w_sectime_inc;
                    end else begin
                        w_run_len_nxt = '0;
                        w_state_nxt   = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_div      <= '0;
            r_rate_cnt <= '0;
            r_elapsed  <= '0;
            r_run_len  <= '0;
            r_state    <= IDLE;
            r_slowclk  <= 1'b0;
            r_stepcnt  <= '0;
            r_distance <= '0;
            r_sec      <= '0;
            r_sectime  <= '0;
        end else begin
            r_div      <= w_tick ? '0 : r_div + DIV_W'(1);
            r_slowclk  <= w_tick;
            r_stepcnt  <= w_stepcnt_nxt;
            r_distance <= {{(DIST_W - STEP_W + HALF_MILE_SHIFT){1'b0}},
                           w_stepcnt_nxt[STEP_W-1:HALF_MILE_SHIFT]};
            r_state    <= w_state_nxt;
            r_run_len  <= w_run_len_nxt;
            r_sectime  <= w_sectime_nxt;
            if (w_tick) begin
                r_rate_cnt <= '0;
                if (r_elapsed != 4'd15)
                    r_elapsed <= r_elapsed + 4'd1;
                if ((r_elapsed < 4'(SEC_WINDOW)) && (w_rate_fin > 9'(SEC_RATE)))
                    r_sec <= r_sec + SEC_W'(1);
            end else if (w_step_edge && (r_rate_cnt != 8'd255)) begin
                r_rate_cnt <= r_rate_cnt + 8'd1;
            end
        end
    end

`ifdef TRACKER_SAT_FLAG_EN
    logic r_sat;

    always_ff @(posedge CLK) begin
        if (!RESET)
            r_sat <= 1'b0;
        else
            r_sat <= (w_stepcnt_nxt == STEP_W'(STEP_MAX)) || (w_sectime_nxt == SECTIME_MAX);
    end

    assign bus.sat = r_sat;
`endif

    assign bus.slowClk  = r_slowclk;
    assign bus.stepcnt  = r_stepcnt;
    assign bus.distance = r_distance;
    assign bus.sec      = r_sec;
    assign bus.sectime  = r_sectime;
endmodule

// File: tb/tb_fitbit_step_tracker.sv
// Bench for fitbit_step_tracker: per-second randomized step loads, expected metrics queued per tick.
// A separate monitor pops and compares on every slowClk pulse.
module tb_fitbit_step_tracker;
    import fitbit_pkg::*;

    // 160 CLK per second leaves room for 79 one-high/one-low pulses per second.
    localparam int C          = 160;
    localparam int STEP_MAX   = 9999;
    localparam int SEC_WINDOW = 9;
    localparam int SEC_RATE   = 32;
    localparam int HI_RATE    = 64;
    localparam int RUN_MIN    = 60;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    fitbit_step_tracker_if bus();

    fitbit_step_tracker #(
        .CLKS_PER_SEC (C),
        .STEP_MAX     (STEP_MAX),
        .SEC_WINDOW   (SEC_WINDOW),
        .SEC_RATE     (SEC_RATE),
        .HI_RATE      (HI_RATE),
        .RUN_MIN      (RUN_MIN)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int tick_at;
        int stepcnt;
        int distance;
        int sec;
        int sectime;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    int m_total;
    int m_sec_idx;
    int m_sec;
    int m_banked;
    int m_run;

    always @(posedge CLK) begin
        if (!RESET) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_total   = 0;
        m_sec_idx = 0;
        m_sec     = 0;
        m_banked  = 0;
        m_run     = 0;
    endtask

    // Metrics straight from the rules: totals clamp, runs of >= RUN_MIN high seconds count in full.
    task automatic model_second(input int steps);
        exp_t e;
        int   rate;
        int   st;
        rate = (steps > 255) ? 255 : steps;
        m_sec_idx++;
        m_total += steps;
        if (m_sec_idx <= SEC_WINDOW && rate > SEC_RATE) m_sec++;
        if (rate >= HI_RATE) begin
            m_run++;
        end else begin
            if (m_run >= RUN_MIN) m_banked += m_run;
            m_run = 0;
        end
        st = m_banked + ((m_run >= RUN_MIN) ? m_run : 0);
        e.tick_at  = m_sec_idx * C;
        e.stepcnt  = (m_total > STEP_MAX) ? STEP_MAX : m_total;
        e.distance = e.stepcnt / 1024;
        e.sec      = m_sec;
        e.sectime  = (st > 511) ? 511 : st;
        exp_q.push_back(e);
    endtask

    // k pulses early in the second; tick_step adds one whose edge lands on the tick cycle.
    task automatic drive_cycles(input int k, input bit tick_step, input int n_cyc);
        for (int j = 1; j <= n_cyc; j++) begin
            bus.PULSE = ((j % 2 == 1) && (j <= 2 * k - 1)) || (tick_step && (j == C - 2));
            @(negedge CLK);
        end
    endtask

    task automatic run_second(input int k, input bit tick_step);
        model_second(k + (tick_step ? 1 : 0));
        drive_cycles(k, tick_step, C);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stepcnt"},  int'(bus.stepcnt),  0);
        check({tag, "_distance"}, int'(bus.distance), 0);
        check({tag, "_sec"},      int'(bus.sec),      0);
        check({tag, "_sectime"},  int'(bus.sectime),  0);
        check({tag, "_slowclk"},  int'(bus.slowClk),  0);
`ifdef TRACKER_SAT_FLAG_EN
        check({tag, "_sat"},      int'(bus.sat),      0);
`endif
    endtask

    task automatic do_reset(input bit toggle, input string tag);
        RESET = 1'b0;
        bus.PULSE = toggle;
        @(negedge CLK);
        check_zero(tag);
        bus.PULSE = 1'b0;
        @(negedge CLK);
        model_reset();
        RESET = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.slowClk) begin
                check("tick_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tick_cycle", cyc, e.tick_at);
                    check("stepcnt",  int'(bus.stepcnt),  e.stepcnt);
                    check("distance", int'(bus.distance), e.distance);
                    check("sec",      int'(bus.sec),      e.sec);
                    check("sectime",  int'(bus.sectime),  e.sectime);
`ifdef TRACKER_SAT_FLAG_EN
                    check("sat", int'(bus.sat),
                          int'(e.stepcnt == STEP_MAX || e.sectime == 511));
`endif
                end
            end else if (RESET && exp_q.size() > 0 && cyc > exp_q[0].tick_at) begin
                e = exp_q.pop_front();
                check("tick_missing_at", cyc, e.tick_at);
            end
        end
    end

    initial begin : stim
        bus.PULSE = 1'b0;
        model_reset();

        do_reset(1'b1, "rst0");

        repeat (10) run_second(40, 1'b0);
        check("win_sec",      int'(bus.sec),      9);
        check("win_stepcnt",  int'(bus.stepcnt),  400);
        check("win_distance", int'(bus.distance), 0);

        do_reset(1'b0, "rst1");
        while (m_total < 10050) run_second($urandom_range(60, 79), 1'b0);
        check("sat_stepcnt",  int'(bus.stepcnt),  STEP_MAX);
        check("sat_distance", int'(bus.distance), 9);
`ifdef TRACKER_SAT_FLAG_EN
        check("sat_flag", int'(bus.sat), 1);
`endif

        do_reset(1'b1, "rst2");
        repeat (59) run_second(70, 1'b0);
        repeat (2)  run_second(10, 1'b0);
        check("short_run_sectime", int'(bus.sectime), 0);
        repeat (59) run_second($urandom_range(64, 79), 1'b0);
        run_second(63, 1'b1);
        repeat (2) run_second(70, 1'b0);
        run_second(63, 1'b0);
        check("long_run_sectime", int'(bus.sectime), 62);

        do_reset(1'b0, "rst3");
        repeat (30) run_second($urandom_range(64, 79), 1'b0);
        drive_cycles(70, 1'b0, 80);
        do_reset(1'b1, "midrun");
        repeat (59) run_second($urandom_range(64, 79), 1'b0);
        check("post_reset_s59", int'(bus.sectime), 0);
        run_second($urandom_range(64, 79), 1'b0);
        check("post_reset_s60", int'(bus.sectime), 60);

        repeat (4) @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
